rx_pause_ctrl: RTL

- Receive-side MAC Control (IEEE 802.3 Annex 31B) PAUSE responder. It is the partner of the transmit pause-frame generator driven by pause_req/pause_val.
- Snoops the decoded rx AXIS stream (between rx datapath and user AXIS output). Detects good PAUSE frames and runs the quanta timer.
- Drives rx_pause_active, which the tx datapath uses to hold off new frames.
- One clock domain (rx clock). Passive: never back-pressures the stream.

---
 rtl/rx_pause_ctrl_pkg.sv | 20 ++
 rtl/rx_pause_ctrl_if.sv | 11 +
 rtl/rx_pause_ctrl_pause_quanta_timer.sv | 45 ++++
 rtl/rx_pause_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/rx_pause_ctrl_pkg.sv
// rtl/rx_pause_ctrl_pkg.sv - MAC Control PAUSE constants, parser states and byte helper
package rx_pause_ctrl_pkg;

    localparam logic [15:0] MAC_CTRL_ETHERTYPE = 16'h8808;
    localparam logic [15:0] PAUSE_OPCODE       = 16'h0001;
    localparam logic [47:0] PAUSE_MCAST_DA     = 48'h0180C2000001;

    typedef enum logic [1:0] {
        ST_HDR0   = 2'd0,
        ST_HDR1   = 2'd1,
        ST_QUANTA = 2'd2,
        ST_SKIP   = 2'd3
    } parse_state_t;

    // Byte n of a beat in wire order (byte 0 sits in the low lane).
    function automatic logic [7:0] beat_byte(input logic [63:0] data, input int unsigned n);
        return data[8*n +: 8];
    endfunction

endpackage

// File: rtl/rx_pause_ctrl_if.sv
// rtl/rx_pause_ctrl_if.sv - decoded rx AXIS snoop bundle
interface rx_pause_ctrl_if;
    logic [63:0] axis_tdata;
    logic [7:0]  axis_tkeep;
    logic        axis_tvalid;
    logic        axis_tlast;
    logic        axis_tuser;

    modport master (output axis_tdata, axis_tkeep, axis_tvalid, axis_tlast, axis_tuser);
    modport slave  (input  axis_tdata, axis_tkeep, axis_tvalid, axis_tlast, axis_tuser);
endinterface

// File: rtl/rx_pause_ctrl_pause_quanta_timer.sv
// rtl/rx_pause_ctrl_pause_quanta_timer.sv - pause quanta countdown with sub-quantum prescaler
module pause_quanta_timer #(
    parameter int QW = 16
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          enable,
    input  logic          load,
    input  logic [QW-1:0] load_value,
    input  logic [7:0]    sub_quanta_count,
    output logic [QW-1:0] remaining,
    output logic          active
);

    logic [7:0] sub;
    logic [7:0] sub_last;

    // A prescale of 0 behaves like 1: every clock is one quantum.
    assign sub_last = (sub_quanta_count == 8'd0) ? 8'd0 : sub_quanta_count - 8'd1;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            remaining <= '0;
            sub       <= '0;
            active    <= 1'b0;
        end else if (!enable) begin
            remaining <= '0;
            sub       <= '0;
            active    <= 1'b0;
        end else if (load) begin
            remaining <= load_value;
            sub       <= '0;
            active    <= (load_value != '0);
        end else if (remaining != '0) begin
            if (sub == sub_last) begin
                sub       <= '0;
                remaining <= remaining - QW'(1);
                active    <= (remaining != QW'(1));
            end else begin
                sub <= sub + 8'd1;
            end
        end
    end

endmodule

// File: rtl/rx_pause_ctrl.sv
// rtl/rx_pause_ctrl.sv - rx PAUSE frame detector and pause timer driver
module rx_pause_ctrl
    import rx_pause_ctrl_pkg::*;
#(
    parameter int C_CNT_WIDTH    = 32,
    parameter int C_QUANTA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      aresetn,
    rx_pause_ctrl_if.slave            axis,
    input  logic                      cfg_rx_pause_enable,
    input  logic [47:0]               cfg_station_macaddr,
    input  logic [7:0]                cfg_sub_quanta_count,
    output logic                      rx_pause_active,
    output logic [C_QUANTA_WIDTH-1:0] pause_quanta_remaining,
    output logic [C_CNT_WIDTH-1:0]    pause_frames
);

    parse_state_t              state;
    logic                      match_da;
    logic                      candidate;
    logic [C_QUANTA_WIDTH-1:0] quanta_q;

    logic [47:0]               beat_da;
    logic                      da_hit;
    logic                      hdr_ok;
    logic [C_QUANTA_WIDTH-1:0] beat_quanta;
    logic [C_QUANTA_WIDTH-1:0] commit_quanta;
    logic                      commit;
    logic                      beat_last;

    wire unused_tkeep = ^axis.axis_tkeep;

    assign beat_da = {beat_byte(axis.axis_tdata, 0), beat_byte(axis.axis_tdata, 1),
                      beat_byte(axis.axis_tdata, 2), beat_byte(axis.axis_tdata, 3),
                      beat_byte(axis.axis_tdata, 4), beat_byte(axis.axis_tdata, 5)};
    assign da_hit  = (beat_da == PAUSE_MCAST_DA) || (beat_da == cfg_station_macaddr);

    // Beat 1 carries frame bytes 8..15: ethertype in lanes 4-5, opcode in lanes 6-7.
    assign hdr_ok = match_da
                 && ({beat_byte(axis.axis_tdata, 4), beat_byte(axis.axis_tdata, 5)} == MAC_CTRL_ETHERTYPE)
                 && ({beat_byte(axis.axis_tdata, 6), beat_byte(axis.axis_tdata, 7)} == PAUSE_OPCODE);

    assign beat_quanta = {beat_byte(axis.axis_tdata, 0), beat_byte(axis.axis_tdata, 1)};
    assign beat_last   = axis.axis_tvalid && axis.axis_tlast;

    // A 3-beat frame ends on the quanta beat itself, so use the live beat there.
    assign commit_quanta = (state == ST_QUANTA) ? beat_quanta : quanta_q;
    assign commit = beat_last && (candidate || (state == ST_QUANTA))
                 && axis.axis_tuser && cfg_rx_pause_enable;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= ST_HDR0;
            match_da     <= 1'b0;
            candidate    <= 1'b0;
            quanta_q     <= '0;
            pause_frames <= '0;
        end else begin
            if (commit) begin
                pause_frames <= pause_frames + C_CNT_WIDTH'(1);
            end
            if (axis.axis_tvalid) begin
                case (state)
                    ST_HDR0: begin
                        match_da <= da_hit;
                        state    <= axis.axis_tlast ? ST_HDR0 : ST_HDR1;
                    end
                    ST_HDR1: begin
                        if (axis.axis_tlast)  state <= ST_HDR0;
                        else if (hdr_ok)      state <= ST_QUANTA;
                        else                  state <= ST_SKIP;
                    end
                    ST_QUANTA: begin
                        quanta_q  <= beat_quanta;
                        candidate <= 1'b1;
                        state     <= axis.axis_tlast ? ST_HDR0 : ST_SKIP;
                    end
                    ST_SKIP: begin
                        if (axis.axis_tlast) state <= ST_HDR0;
                    end
                endcase
                if (axis.axis_tlast) begin
                    candidate <= 1'b0;
                end
            end
        end
    end

    pause_quanta_timer #(
        .QW (C_QUANTA_WIDTH)
    ) u_timer (
        .clk              (clk),
        .aresetn          (aresetn),
        .enable           (cfg_rx_pause_enable),
        .load             (commit),
        .load_value       (commit_quanta),
        .sub_quanta_count (cfg_sub_quanta_count),
        .remaining        (pause_quanta_remaining),
        .active           (rx_pause_active)
    );

endmodule
